// File: rtl/sipo_param_if.sv
// Serial-in / word-out bundle for sipo_param.
// master drives the serial bits and word_ready_i; slave is the converter.
`timescale 1ns/1ps
interface sipo_param_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = $clog2(DATA_W + 1)
);
    logic              data_serial_i;
    logic              valid_serial_i;
    logic              serial_ready_o;
    logic              flush_i;
    logic [DATA_W-1:0] data_parallel_o;
    logic [CNT_W-1:0]  nbits_o;
    logic              word_valid_o;
    logic              word_ready_i;
    logic              overflow_o;

    modport master (
        output data_serial_i, valid_serial_i, flush_i, word_ready_i,
        input  serial_ready_o, data_parallel_o, nbits_o,
        input  word_valid_o, overflow_o
    );

    modport slave (
        input  data_serial_i, valid_serial_i, flush_i, word_ready_i,
        output serial_ready_o, data_parallel_o, nbits_o,
        output word_valid_o, overflow_o
    );
endinterface

// File: rtl/sipo_param.sv
// Serial-to-parallel converter with one-entry output register and backpressure.
// Optional partial-word flush is enabled by defining SIPO_FLUSH_EN.
`timescale 1ns/1ps
module sipo_param #(
    parameter int DATA_W    = 8,
    parameter int MSB_FIRST = 0,
    parameter int CNT_W     = $clog2(DATA_W + 1)
) (
    input logic         clk,
    input logic         rst_n,
    sipo_param_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] FULL_N = CNT_W'(DATA_W);

    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_nx;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic [CNT_W-1:0]  idx;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  out_nbits;
    logic              out_full;
    logic              ovf;
    logic              ready;
    logic              accept;
    logic              last;
    logic              drain;
    logic              load;
    logic [CNT_W-1:0]  load_nbits;

    // Ready looks only at registered state, never at word_ready_i.
    assign ready   = !(out_full && cnt == LAST);
    assign accept  = bus.valid_serial_i && ready;
    assign last    = accept && cnt == LAST;
    assign drain   = out_full && bus.word_ready_i;
    assign idx     = (MSB_FIRST != 0) ? LAST - cnt : cnt;
    assign cnt_inc = cnt + CNT_W'(accept);

    always_comb begin
        acc_nx = acc;
        if (accept) acc_nx[idx] = bus.data_serial_i;
    end

`ifdef SIPO_FLUSH_EN
    logic pend;
    logic flush_req;
    logic reg_free;
    logic do_flush;

    assign flush_req = bus.flush_i || pend;
    assign reg_free  = !out_full || bus.word_ready_i;
    assign do_flush  = !last && flush_req &&
                       cnt_inc != '0 && reg_free;

    // A flush that finds the register busy waits here with its bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= 1'b0;
        end else if (last || do_flush) begin
            pend <= 1'b0;
        end else begin
            pend <= flush_req && cnt_inc != '0;
        end
    end

    always_comb begin
        load       = last;
        load_nbits = FULL_N;
        if (do_flush) begin
            load       = 1'b1;
            load_nbits = cnt_inc;
        end
    end
`else
    logic unused_flush;
    assign unused_flush = bus.flush_i;

    always_comb begin
        load       = last;
        load_nbits = FULL_N;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_nbits <= '0;
            out_full  <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (load) begin
                out_data  <= acc_nx;
                out_nbits <= load_nbits;
                out_full  <= 1'b1;
                acc       <= '0;
                cnt       <= '0;
            end else begin
                acc <= acc_nx;
                cnt <= cnt_inc;
                if (drain) out_full <= 1'b0;
            end
            if (bus.valid_serial_i && !ready) ovf <= 1'b1;
        end
    end

    assign bus.serial_ready_o  = ready;
    assign bus.data_parallel_o = out_data;
    assign bus.nbits_o         = out_nbits;
    assign bus.word_valid_o    = out_full;
    assign bus.overflow_o      = ovf;
endmodule

// File: doc/sipo_param.md
# sipo_param

Parametrised serial-to-parallel converter for the decoder output path. It assembles a stream of decoded bits into words of DATA_W bits, with a selectable bit order. Each completed word is held in a one-entry output register behind a valid/ready handshake, and serial backpressure is provided through serial_ready_o. It replaces the fixed 8-bit, LSB-first, pulse-only deserialiser that sits between the Viterbi traceback and the byte sink.

## Interface
- DATA_W, 8, word width in bits; must be at least 2.
- MSB_FIRST, 0, bit order. 0 means the first received bit lands in bit 0. 1 means the first received bit lands in bit DATA_W-1.
- CNT_W, $clog2(DATA_W+1), width of the bit counter and of nbits_o (derived).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- data_serial_i  in  1  serial data bit
- valid_serial_i  in  1  data_serial_i is valid this cycle
- serial_ready_o  out  1  block can accept a bit this cycle
- flush_i  in  1  emit the partial word (only with SIPO_FLUSH_EN)
- data_parallel_o  out  DATA_W  assembled word; valid while word_valid_o=1
- nbits_o  out  CNT_W  number of valid bits in data_parallel_o
- word_valid_o  out  1  output register holds a word
- word_ready_i  in  1  sink accepts the word
- overflow_o  out  1  sticky flag: a bit was presented while serial_ready_o=0

## Operation
- State:
  - accumulator acc[DATA_W-1:0]
  - counter cnt (0..DATA_W-1)
  - output register (data, nbits, full flag)
  - overflow flag
- A bit is accepted on a rising edge when valid_serial_i=1 and serial_ready_o=1.
  - MSB_FIRST=0: the bit is written to acc[cnt].
  - MSB_FIRST=1: the bit is written to acc[DATA_W-1-cnt].
  - cnt then increments.
- Word completion: the accepted bit is the DATA_W-th bit (cnt==DATA_W-1).
  - On that same edge, the full word (acc plus the new bit) loads the output register.
  - nbits_o is set to DATA_W, word_valid_o to 1, and cnt to 0.
  - acc clears to 0.
- Output handshake:
  - A word transfers on an edge where word_valid_o=1 and word_ready_i=1. word_valid_o then drops unless a new word loads on the same edge.
  - data_parallel_o and nbits_o are stable while word_valid_o=1 and word_ready_i=0.
- Backpressure: serial_ready_o = !(word_valid_o && cnt==DATA_W-1).
  - It depends on registered state only; there is no combinational path from word_ready_i or valid_serial_i.
  - Consequence: one bubble cycle after a stalled word is drained.
- Overflow: if valid_serial_i=1 while serial_ready_o=0, the bit is dropped and overflow_o sets. overflow_o clears only on reset.
- Bits arriving while an earlier word waits in the output register are accumulated normally, up to DATA_W-1 bits.

## Timing
- Reset values:
  - serial_ready_o=1
  - data_parallel_o=0
  - nbits_o=0
  - word_valid_o=0
  - overflow_o=0
  - cnt=0, acc=0
- Latency: word_valid_o rises on the edge that samples the last bit. It is visible in the following cycle, so one clock after the last bit is presented.
- Throughput: with word_ready_i tied to 1, there is one word every DATA_W cycles and no gaps.
- Asynchronous reset mid-word or mid-handshake:
  - A held word and any partial bits are discarded.
  - All outputs return to their reset values immediately, without waiting for a clock edge.

## Configuration
- Macro: SIPO_FLUSH_EN.
- When defined, flush_i is sampled on each rising edge.
- Flush when cnt>0 and the output register is free:
  - The partial word loads the output register with nbits_o=cnt.
  - Unfilled bits are 0. The valid bits are in [cnt-1:0] for MSB_FIRST=0, or in [DATA_W-1:DATA_W-cnt] for MSB_FIRST=1.
  - cnt and acc then clear.
- A bit accepted on the flush edge is included in the flushed word. If that bit completes the word, it is a normal full word with nbits_o=DATA_W.
- If the output register is occupied, the flush is latched as pending and executes on the first edge where the register is free.
  - Bits accepted while the flush is pending are included in the flushed word.
- A flush with cnt==0 and no accepted bit is a no-op, and it clears any pending flush.
- When not defined, flush_i is ignored, no pending-flush state exists, and nbits_o is a constant DATA_W after the first word.

## Test plan
- Byte order, DATA_W=8, MSB_FIRST=0, word_ready_i=1: send 0xA5 LSB-first.
  - data_parallel_o=0xA5, nbits_o=8, word_valid_o high for 1 cycle, one clock after the 8th bit.
- Bit order: send the stream 1,0,0,0,0,0,0,0.
  - MSB_FIRST=0 gives 0x01; MSB_FIRST=1 gives 0x80.
- Backpressure, word_ready_i=0: stream 16 bits 0xFF, then 0x00.
  - The first word 0xFF is held.
  - serial_ready_o falls after the 15th bit is accepted.
  - Raise word_ready_i: 0xFF transfers, serial_ready_o rises the next cycle, the 16th bit is accepted, and 0x00 is presented. overflow_o stays 0.
- Overflow: repeat the backpressure case but keep valid_serial_i=1 while serial_ready_o=0.
  - overflow_o=1 and stays set until reset.
  - The dropped bit is absent from the second word.
- Flush (SIPO_FLUSH_EN, MSB_FIRST=0): bits 1,0,1, then a flush_i pulse.
  - data_parallel_o=0x05, nbits_o=3.
  - Repeat with the output register occupied: the flush is deferred until the held word drains.
- Reset mid-word: 5 bits in, pulse rst_n low.
  - All outputs are 0 and serial_ready_o=1.
  - The next 8 bits of 0x3C yield exactly 0x3C.
